moo_arb: RTL and testbench

Two-requester job arbiter and sequencer for the shared `moo_cu`/ARIA engine. It grants whole jobs round-robin and latches the winner's job descriptor. It then issues the one-cycle `moo_en` start and routes the winner's data-in, data-out and additional-data streams to the engine. On completion, timeout or cancel it releases the engine with `moo_clr`. It sits between the host-side channels (SPI command path, DMA path) and `moo_cu`.

---
 rtl/moo_arb.sv | 221 ++++++++++++++++++++++
 tb/tb_moo_arb.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/moo_arb.sv
`default_nettype none
// ============================================================================
//  Module   : moo_arb
//  Purpose  : Two-requester job arbiter/sequencer for the shared moo_cu engine.
//             Grants whole jobs round-robin, latches the winner's descriptor,
//             issues a one-cycle moo_en, routes the winner's data-in/data-out/
//             additional-data streams to the engine while running, and
//             releases the engine with a one-cycle moo_clr on completion,
//             watchdog timeout or cancel.
//  Ports    : clk, rst (async, active-high)
//             req/req_op/req_add/req_ksz      - per-requester job requests
//             gnt/busy/done/err               - requester status
//             di_*, do_*, ad_*                - per-requester streams
//                                               (do_data is the broadcast
//                                               data-out bus, 2*DW wide)
//             moo_en/clr/op/add, key_size     - engine control
//             moo_rdy/moo_done                - engine status
//             moo_di_*, moo_do_*, moo_add_*   - engine-side streams
//  Revision : 1.0 - initial release
// ============================================================================
module moo_arb #(
   parameter int             DW     = 128,
   parameter int             TO_W   = 16,
   parameter logic [TO_W-1:0] TO_MAX = 16'hFFFF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        req,
   input  logic [7:0]        req_op,
   input  logic [1:0]        req_add,
   input  logic [3:0]        req_ksz,
   output logic [1:0]        gnt,
   output logic              busy,
   output logic [1:0]        done,
   output logic [1:0]        err,
   input  logic [1:0]        di_vld,
   input  logic [1:0]        di_lst,
   input  logic [2*DW-1:0]   di,
   output logic [1:0]        di_rdy,
   input  logic [1:0]        do_rdy,
   output logic [1:0]        do_vld,
   output logic [2*DW-1:0]   do_data,
   input  logic [1:0]        ad_vld,
   input  logic [1:0]        ad_lst,
   input  logic [2*DW-1:0]   ad,
   output logic [1:0]        ad_rdy,
   output logic              moo_en,
   output logic              moo_clr,
   output logic [3:0]        moo_op,
   output logic              moo_add,
   output logic [1:0]        key_size,
   input  logic              moo_rdy,
   input  logic              moo_done,
   output logic              moo_di_vld,
   output logic              moo_di_lst,
   output logic [DW-1:0]     moo_di,
   input  logic              moo_di_rdy,
   input  logic              moo_do_vld,
   input  logic [DW-1:0]     moo_do,
   output logic              moo_do_rdy,
   output logic              moo_add_vld,
   output logic              moo_add_lst,
   output logic [DW-1:0]     moo_add_d,
   input  logic              moo_add_rdy
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_RUN   = 3'd2,
      S_REL   = 3'd3,
      S_ABORT = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic              g_q, g_d;        // index of the granted requester
   logic              lp_q, lp_d;      // last-granted requester
   logic [1:0]        gnt_q, gnt_d;
   logic [3:0]        op_q, op_d;
   logic              add_q, add_d;
   logic [1:0]        ksz_q, ksz_d;
   logic              to_q, to_d;      // abort was caused by the watchdog
   logic [TO_W-1:0]   wd_q, wd_d;

   logic              win;
   logic              hs;
   logic              wd_hit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         g_q     <= 1'b0;
         lp_q    <= 1'b1;
         gnt_q   <= 2'b00;
         op_q    <= 4'h0;
         add_q   <= 1'b0;
         ksz_q   <= 2'b00;
         to_q    <= 1'b0;
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         g_q     <= g_d;
         lp_q    <= lp_d;
         gnt_q   <= gnt_d;
         op_q    <= op_d;
         add_q   <= add_d;
         ksz_q   <= ksz_d;
         to_q    <= to_d;
         wd_q    <= wd_d;
      end
   end

   // Any engine-side transfer on the granted streams counts as progress.
   assign hs = (di_vld[g_q] & moo_di_rdy) |
               (moo_do_vld & do_rdy[g_q]) |
               (ad_vld[g_q] & moo_add_rdy);

   assign wd_hit = (TO_MAX != '0) && (wd_q == TO_MAX);

   always_comb begin
      state_d     = state_q;
      g_d         = g_q;
      lp_d        = lp_q;
      gnt_d       = gnt_q;
      op_d        = op_q;
      add_d       = add_q;
      ksz_d       = ksz_q;
      to_d        = to_q;
      wd_d        = '0;
      win         = 1'b0;
      moo_en      = 1'b0;
      moo_clr     = 1'b0;
      done        = 2'b00;
      err         = 2'b00;
      di_rdy      = 2'b00;
      do_vld      = 2'b00;
      do_data     = '0;
      ad_rdy      = 2'b00;
      moo_di_vld  = 1'b0;
      moo_di_lst  = 1'b0;
      moo_di      = '0;
      moo_do_rdy  = 1'b0;
      moo_add_vld = 1'b0;
      moo_add_lst = 1'b0;
      moo_add_d   = '0;

      case (state_q)
         S_IDLE: begin
            if (moo_rdy && (req != 2'b00)) begin
               // Tie goes to the requester that was not served last.
               win     = (req == 2'b11) ? ~lp_q : req[1];
               g_d     = win;
               gnt_d   = win ? 2'b10 : 2'b01;
               op_d    = win ? req_op[7:4]  : req_op[3:0];
               add_d   = win ? req_add[1]   : req_add[0];
               ksz_d   = win ? req_ksz[3:2] : req_ksz[1:0];
               to_d    = 1'b0;
               state_d = S_ISSUE;
            end
         end

         S_ISSUE: begin
            moo_en  = 1'b1;
            state_d = S_RUN;
         end

         S_RUN: begin
            moo_di_vld     = di_vld[g_q];
            moo_di_lst     = di_lst[g_q];
            moo_di         = di[g_q*DW +: DW];
            di_rdy[g_q]    = moo_di_rdy;
            do_vld[g_q]    = moo_do_vld;
            do_data        = {2{moo_do}};
            moo_do_rdy     = do_rdy[g_q];
            moo_add_vld    = ad_vld[g_q];
            moo_add_lst    = ad_lst[g_q];
            moo_add_d      = ad[g_q*DW +: DW];
            ad_rdy[g_q]    = moo_add_rdy;

            wd_d = hs ? '0 : wd_q + 1'b1;

            if (!req[g_q]) begin
               to_d    = 1'b0;
               state_d = S_ABORT;
            end else if (wd_hit) begin
               to_d    = 1'b1;
               state_d = S_ABORT;
            end else if (moo_done || moo_rdy) begin
               // moo_rdy alone ends jobs that never raise moo_done.
               state_d = S_REL;
            end
         end

         S_REL: begin
            moo_clr    = 1'b1;
            done[g_q]  = 1'b1;
            lp_d       = g_q;
            gnt_d      = 2'b00;
            state_d    = S_IDLE;
         end

         S_ABORT: begin
            moo_clr    = 1'b1;
            err[g_q]   = to_q;
            lp_d       = g_q;
            gnt_d      = 2'b00;
            state_d    = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   assign gnt      = gnt_q;
   assign busy     = (state_q != S_IDLE);
   assign moo_op   = op_q;
   assign moo_add  = add_q;
   assign key_size = ksz_q;

endmodule
`default_nettype wire

// File: tb/tb_moo_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_moo_arb
//  Purpose  : Directed self-checking bench for moo_arb (TO_MAX = 8).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_moo_arb;
   localparam int DW = 128;

   logic            clk = 1'b0;
   logic            rst;
   logic [1:0]      req;
   logic [7:0]      req_op;
   logic [1:0]      req_add;
   logic [3:0]      req_ksz;
   logic [1:0]      gnt, done, err;
   logic            busy;
   logic [1:0]      di_vld, di_lst, di_rdy;
   logic [2*DW-1:0] di;
   logic [1:0]      do_rdy, do_vld;
   logic [2*DW-1:0] do_data;
   logic [1:0]      ad_vld, ad_lst, ad_rdy;
   logic [2*DW-1:0] ad;
   logic            moo_en, moo_clr, moo_add;
   logic [3:0]      moo_op;
   logic [1:0]      key_size;
   logic            moo_rdy, moo_done;
   logic            moo_di_vld, moo_di_lst, moo_di_rdy;
   logic [DW-1:0]   moo_di;
   logic            moo_do_vld, moo_do_rdy;
   logic [DW-1:0]   moo_do;
   logic            moo_add_vld, moo_add_lst, moo_add_rdy;
   logic [DW-1:0]   moo_add_d;

   int n_tests = 0;
   int n_fail  = 0;

   logic [DW-1:0] pat0, pat1, patx, pata0, pata1;

   always #5 clk = ~clk;

   moo_arb #(.DW(DW), .TO_W(16), .TO_MAX(16'd8)) dut (
      .clk(clk), .rst(rst),
      .req(req), .req_op(req_op), .req_add(req_add), .req_ksz(req_ksz),
      .gnt(gnt), .busy(busy), .done(done), .err(err),
      .di_vld(di_vld), .di_lst(di_lst), .di(di), .di_rdy(di_rdy),
      .do_rdy(do_rdy), .do_vld(do_vld), .do_data(do_data),
      .ad_vld(ad_vld), .ad_lst(ad_lst), .ad(ad), .ad_rdy(ad_rdy),
      .moo_en(moo_en), .moo_clr(moo_clr), .moo_op(moo_op),
      .moo_add(moo_add), .key_size(key_size),
      .moo_rdy(moo_rdy), .moo_done(moo_done),
      .moo_di_vld(moo_di_vld), .moo_di_lst(moo_di_lst), .moo_di(moo_di),
      .moo_di_rdy(moo_di_rdy),
      .moo_do_vld(moo_do_vld), .moo_do(moo_do), .moo_do_rdy(moo_do_rdy),
      .moo_add_vld(moo_add_vld), .moo_add_lst(moo_add_lst),
      .moo_add_d(moo_add_d), .moo_add_rdy(moo_add_rdy)
   );

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance into the next cycle; inputs set afterwards are sampled at the following edge.
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic streams_off();
      di_vld = 2'b00; di_lst = 2'b00; di = '0;
      do_rdy = 2'b00;
      ad_vld = 2'b00; ad_lst = 2'b00; ad = '0;
      moo_di_rdy = 1'b0; moo_do_vld = 1'b0; moo_do = '0; moo_add_rdy = 1'b0;
   endtask

   initial begin
      pat0  = {4{32'h0123_4567}};
      pat1  = {4{32'hDEAD_BEEF}};
      patx  = {4{32'hCAFE_F00D}};
      pata0 = {4{32'h1111_2222}};
      pata1 = {4{32'h3333_4444}};

      rst = 1'b1;
      req = 2'b00; req_op = 8'h00; req_add = 2'b00; req_ksz = 4'h0;
      moo_rdy = 1'b1; moo_done = 1'b0;
      streams_off();
      #1;
      // ---------------- reset state ----------------
      chk("rst_gnt",  gnt, 2'b00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_en",   moo_en, 1'b0);
      chk("rst_clr",  moo_clr, 1'b0);
      chk("rst_op",   moo_op, 4'h0);
      cyc(); cyc();
      rst = 1'b0;
      cyc();

      // ---------------- requester 0 alone ----------------
      req = 2'b01; req_op = 8'h04; req_ksz = 4'b0001;
      cyc();                                   // ISSUE
      chk("a_gnt",  gnt, 2'b01);
      chk("a_en",   moo_en, 1'b1);
      chk("a_op",   moo_op, 4'h4);
      chk("a_ksz",  key_size, 2'd1);
      chk("a_busy", busy, 1'b1);
      moo_rdy = 1'b0;
      cyc();                                   // RUN
      chk("a_en_once", moo_en, 1'b0);
      di_vld = 2'b01; di = {pat1, pat0}; moo_di_rdy = 1'b1;
      #1;
      chk("a_moo_di", moo_di, pat0);
      chk("a_di_rdy", di_rdy, 2'b01);
      cyc();                                   // RUN
      streams_off();
      moo_done = 1'b1;
      cyc();                                   // REL
      chk("a_clr",  moo_clr, 1'b1);
      chk("a_done", done, 2'b01);
      chk("a_busy_rel", busy, 1'b1);
      moo_done = 1'b0; req = 2'b00; moo_rdy = 1'b1;
      cyc();                                   // IDLE
      chk("a_busy_fall", busy, 1'b0);
      chk("a_done_one",  done, 2'b00);
      chk("a_clr_one",   moo_clr, 1'b0);

      // ---------------- both requesting after reset ----------------
      rst = 1'b1; #1; rst = 1'b0;
      req = 2'b11;
      for (int k = 0; k < 4; k++) begin
         cyc();                                // ISSUE
         chk("b_gnt", gnt, (k % 2 == 0) ? 2'b01 : 2'b10);
         cyc();                                // RUN (moo_rdy high -> REL)
         chk("b_gnt_run", gnt, (k % 2 == 0) ? 2'b01 : 2'b10);
         cyc();                                // REL
         chk("b_done", done, (k % 2 == 0) ? 2'b01 : 2'b10);
         cyc();                                // IDLE
         chk("b_gnt_idle", gnt, 2'b00);
         if (k == 3) req = 2'b00;
      end

      // ---------------- requester 1 streaming ----------------
      req = 2'b10; req_op = 8'hA0; req_ksz = 4'b1000; req_add = 2'b10;
      cyc();                                   // ISSUE
      chk("c_gnt", gnt, 2'b10);
      chk("c_op",  moo_op, 4'hA);
      chk("c_ksz", key_size, 2'd2);
      chk("c_add", moo_add, 1'b1);
      req_op = 8'hFF; req_ksz = 4'hF; req_add = 2'b00; moo_rdy = 1'b0;
      cyc();                                   // RUN
      chk("c_op_frozen", moo_op, 4'hA);
      chk("c_ksz_frozen", key_size, 2'd2);
      di_vld = 2'b11; di_lst = 2'b10; di = {pat1, pat0}; moo_di_rdy = 1'b1;
      moo_do_vld = 1'b1; moo_do = patx; do_rdy = 2'b11;
      ad_vld = 2'b10; ad_lst = 2'b10; ad = {pata1, pata0}; moo_add_rdy = 1'b1;
      #1;
      chk("c_moo_di",  moo_di, pat1);
      chk("c_di_lst",  moo_di_lst, 1'b1);
      chk("c_di_rdy",  di_rdy, 2'b10);
      chk("c_do_vld",  do_vld, 2'b10);
      chk("c_do_data", do_data, {patx, patx});
      chk("c_do_rdy",  moo_do_rdy, 1'b1);
      chk("c_add_d",   moo_add_d, pata1);
      chk("c_ad_rdy",  ad_rdy, 2'b10);
      moo_done = 1'b1;
      cyc();                                   // REL
      chk("c_done",    done, 2'b10);
      chk("c_di_off",  moo_di, {DW{1'b0}});
      chk("c_rdy_off", di_rdy, 2'b00);
      moo_done = 1'b0; req = 2'b00; moo_rdy = 1'b1;
      streams_off();
      cyc();                                   // IDLE, lp = 1

      // ---------------- watchdog (TO_MAX = 8) ----------------
      req = 2'b11; req_ksz = 4'h5; req_op = 8'h21;
      cyc();                                   // ISSUE
      chk("d_gnt", gnt, 2'b01);
      moo_rdy = 1'b0;
      // RUN cycles carry counter values 0..8; the one holding 8 trips.
      for (int i = 0; i < 9; i++) begin
         cyc();
         chk("d_run_err", err, 2'b00);
         chk("d_run_clr", moo_clr, 1'b0);
      end
      cyc();                                   // ABORT
      chk("d_clr",  moo_clr, 1'b1);
      chk("d_err",  err, 2'b01);
      chk("d_done", done, 2'b00);
      moo_rdy = 1'b1;
      cyc();                                   // IDLE
      chk("d_err_one", err, 2'b00);
      cyc();                                   // ISSUE
      chk("d_next_gnt", gnt, 2'b10);

      // ---------------- cancel mid-RUN ----------------
      moo_rdy = 1'b0;
      cyc();                                   // RUN
      cyc();                                   // RUN
      chk("e_busy", busy, 1'b1);
      req = 2'b01;
      cyc();                                   // ABORT
      chk("e_clr",  moo_clr, 1'b1);
      chk("e_done", done, 2'b00);
      chk("e_err",  err, 2'b00);
      moo_rdy = 1'b1;
      cyc();                                   // IDLE

      // ---------------- reset mid-RUN ----------------
      cyc();                                   // ISSUE
      chk("f_gnt", gnt, 2'b01);
      moo_rdy = 1'b0;
      cyc();                                   // RUN
      di_vld = 2'b01; moo_di_rdy = 1'b1;
      #1;
      chk("f_di_rdy_pre", di_rdy, 2'b01);
      rst = 1'b1;
      #1;
      chk("f_gnt_rst",  gnt, 2'b00);
      chk("f_busy_rst", busy, 1'b0);
      chk("f_di_rdy",   di_rdy, 2'b00);
      chk("f_di_vld",   moo_di_vld, 1'b0);
      chk("f_op_rst",   moo_op, 4'h0);
      chk("f_clr_rst",  moo_clr, 1'b0);
      req = 2'b00; streams_off(); moo_rdy = 1'b1;
      cyc();
      rst = 1'b0;
      cyc();

      // ---------------- ksz = 0 job, moo_rdy stays high ----------------
      req = 2'b01; req_ksz = 4'h0; req_op = 8'h03;
      cyc();                                   // t+1 ISSUE
      chk("g_done_t1", done, 2'b00);
      cyc();                                   // t+2 RUN
      chk("g_done_t2", done, 2'b00);
      cyc();                                   // t+3 REL
      chk("g_done_t3", done, 2'b01);
      chk("g_err",     err, 2'b00);
      req = 2'b00;
      cyc();
      chk("g_idle", busy, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
